inst_prefetch: RTL and testbench

INST_PREFETCH -- requirements
Module: inst_prefetch

---
 rtl/inst_prefetch.sv | 127 ++++++++++++
 tb/tb_inst_prefetch.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_prefetch.sv
// Instruction prefetch queue: fetches sequential words from instruction memory
// into a DEPTH-entry FIFO, with flush-on-redirect and a sticky misalignment flag.
module inst_prefetch #(
    parameter int         DEPTH    = 4,
    parameter logic [7:0] RESET_PC = 8'h00
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fetch_en,
    input  logic        redirect_valid,
    input  logic [7:0]  redirect_pc,
    output logic [5:0]  imem_addr,
    input  logic [31:0] imem_data,
    output logic        inst_valid,
    output logic [31:0] inst_data,
    output logic [7:0]  inst_pc,
    input  logic        inst_ready,
    output logic [3:0]  q_count,
    output logic        misalign_err
);

    localparam int         PTR_W   = $clog2(DEPTH);
    localparam logic [3:0] DEPTH_C = 4'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_FULL
    } state_t;

    state_t            r_state;
    logic [7:0]        r_fetch_pc;
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [3:0]        r_count;
    logic              r_misalign;
    logic [31:0]       r_q_data [DEPTH];
    logic [7:0]        r_q_pc   [DEPTH];

    logic              w_pop;
    logic              w_push;
    logic [3:0]        w_count_nxt;

    assign w_pop  = (r_count != 4'd0) & inst_ready;
    assign w_push = (r_state == ST_FETCH) & fetch_en & ~redirect_valid &
                    ((r_count < DEPTH_C) | w_pop);

    always_comb begin
        w_count_nxt = r_count;
        if (redirect_valid) begin
            w_count_nxt = 4'd0;
        end else if (w_push && !w_pop) begin
            w_count_nxt = r_count + 4'd1;
        end else if (w_pop && !w_push) begin
            w_count_nxt = r_count - 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_fetch_pc <= RESET_PC;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= 4'd0;
            r_misalign <= 1'b0;
        end else begin
            r_count <= w_count_nxt;
            // A redirect wins over any push or pop in the same cycle.
            if (redirect_valid) begin
                r_wr_ptr   <= '0;
                r_rd_ptr   <= '0;
                r_fetch_pc <= {redirect_pc[7:2], 2'b00};
                if (redirect_pc[1:0] != 2'b00) begin
                    r_misalign <= 1'b1;
                end
            end else begin
                if (w_push) begin
                    r_wr_ptr   <= r_wr_ptr + 1'b1;
                    r_fetch_pc <= r_fetch_pc + 8'd4;
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + 1'b1;
                end
            end

            if (!fetch_en) begin
                r_state <= ST_IDLE;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (!redirect_valid) begin
                            r_state <= ST_FETCH;
                        end
                    end
                    ST_FETCH: begin
                        if (!redirect_valid && !w_pop && (w_count_nxt == DEPTH_C)) begin
                            r_state <= ST_FULL;
                        end
                    end
                    ST_FULL: begin
                        if (redirect_valid || w_pop) begin
                            r_state <= ST_FETCH;
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    // Queue payload needs no reset: it is only visible when r_count says so.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_q_data[r_wr_ptr] <= imem_data;
            r_q_pc[r_wr_ptr]   <= r_fetch_pc;
        end
    end

    assign imem_addr    = r_fetch_pc[7:2];
    assign inst_valid   = (r_count != 4'd0);
    assign inst_data    = inst_valid ? r_q_data[r_rd_ptr] : 32'd0;
    assign inst_pc      = inst_valid ? r_q_pc[r_rd_ptr] : 8'd0;
    assign q_count      = r_count;
    assign misalign_err = r_misalign;

endmodule

// File: tb/tb_inst_prefetch.sv
// Bench for inst_prefetch: a queue-based reference model checked every cycle,
// plus directed scenarios with literal expected values.
module tb_inst_prefetch;

    localparam int         DEPTH    = 4;
    localparam logic [7:0] RESET_PC = 8'h00;

    logic        clk;
    logic        rst_n;
    logic        fetch_en;
    logic        redirect_valid;
    logic [7:0]  redirect_pc;
    logic [5:0]  imem_addr;
    logic [31:0] imem_data;
    logic        inst_valid;
    logic [31:0] inst_data;
    logic [7:0]  inst_pc;
    logic        inst_ready;
    logic [3:0]  q_count;
    logic        misalign_err;

    int n_tests = 0;
    int n_fail  = 0;

    inst_prefetch #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .fetch_en       (fetch_en),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_addr      (imem_addr),
        .imem_data      (imem_data),
        .inst_valid     (inst_valid),
        .inst_data      (inst_data),
        .inst_pc        (inst_pc),
        .inst_ready     (inst_ready),
        .q_count        (q_count),
        .misalign_err   (misalign_err)
    );

    assign imem_data = 32'hA000_0000 + {26'd0, imem_addr};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a queue of {pc, word} entries and the fetch rules.
    typedef enum int {M_IDLE, M_FETCH, M_FULL} mstate_t;
    mstate_t     m_st  = M_IDLE;
    logic [7:0]  m_pc  = RESET_PC;
    logic        m_mis = 1'b0;
    logic [39:0] mq[$];
    bit          m_pop;
    bit          m_push;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            m_pc  = RESET_PC;
            m_st  = M_IDLE;
            m_mis = 1'b0;
        end else begin
            m_pop  = (mq.size() != 0) && inst_ready;
            m_push = (m_st == M_FETCH) && fetch_en && !redirect_valid &&
                     ((mq.size() < DEPTH) || m_pop);
            if (redirect_valid) begin
                mq.delete();
                m_pc = {redirect_pc[7:2], 2'b00};
                if (redirect_pc[1:0] != 2'b00) m_mis = 1'b1;
            end else begin
                if (m_pop) void'(mq.pop_front());
                if (m_push) begin
                    mq.push_back({m_pc, 32'hA000_0000 + {26'd0, m_pc[7:2]}});
                    m_pc = m_pc + 8'd4;
                end
            end
            if (!fetch_en)                m_st = M_IDLE;
            else if (m_st == M_IDLE)      m_st = redirect_valid ? M_IDLE : M_FETCH;
            else if (redirect_valid)      m_st = M_FETCH;
            else if (!m_pop && mq.size() == DEPTH) m_st = M_FULL;
            else                          m_st = M_FETCH;
        end
    end

    logic [39:0] e_head;
    always @(negedge clk) begin
        e_head = (mq.size() != 0) ? mq[0] : 40'd0;
        chk("model_valid",    {31'd0, inst_valid},   {31'd0, mq.size() != 0});
        chk("model_pc",       {24'd0, inst_pc},      {24'd0, e_head[39:32]});
        chk("model_data",     inst_data,             e_head[31:0]);
        chk("model_count",    {28'd0, q_count},      32'(mq.size()));
        chk("model_addr",     {26'd0, imem_addr},    {26'd0, m_pc[7:2]});
        chk("model_misalign", {31'd0, misalign_err}, {31'd0, m_mis});
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cyc();
        cyc();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n          = 1'b0;
        fetch_en       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 8'h00;
        inst_ready     = 1'b0;
        cyc();
        cyc();
        chk("rst_valid",    {31'd0, inst_valid},   32'd0);
        chk("rst_count",    {28'd0, q_count},      32'd0);
        chk("rst_addr",     {26'd0, imem_addr},    {26'd0, RESET_PC[7:2]});
        chk("rst_pc",       {24'd0, inst_pc},      32'd0);
        chk("rst_data",     inst_data,             32'd0);
        chk("rst_misalign", {31'd0, misalign_err}, 32'd0);

        // Streaming from reset with the consumer always ready
        rst_n      = 1'b1;
        fetch_en   = 1'b1;
        inst_ready = 1'b1;
        cyc();
        chk("lat_valid_e1", {31'd0, inst_valid}, 32'd0);
        cyc();
        chk("stream_pc0",   {24'd0, inst_pc}, 32'h00);
        chk("stream_data0", inst_data,        32'hA000_0000);
        cyc();
        chk("stream_pc1",   {24'd0, inst_pc}, 32'h04);
        chk("stream_data1", inst_data,        32'hA000_0001);
        cyc();
        chk("stream_pc2",   {24'd0, inst_pc}, 32'h08);
        chk("stream_data2", inst_data,        32'hA000_0002);

        // Fill to full with the consumer stalled
        inst_ready = 1'b0;
        do_reset();
        cyc();
        chk("fill_cnt0", {28'd0, q_count}, 32'd0);
        for (int i = 1; i <= DEPTH; i++) begin
            cyc();
            chk("fill_cnt", {28'd0, q_count}, 32'(i));
        end
        cyc();
        chk("full_cnt",  {28'd0, q_count},   32'd4);
        chk("full_addr", {26'd0, imem_addr}, 32'd4);
        inst_ready = 1'b1;
        cyc();
        chk("full_pop_cnt", {28'd0, q_count}, 32'd3);
        inst_ready = 1'b0;
        cyc();
        chk("refill_cnt",  {28'd0, q_count},   32'd4);
        chk("refill_addr", {26'd0, imem_addr}, 32'd5);
        cyc();
        chk("refill_hold_cnt",  {28'd0, q_count},   32'd4);
        chk("refill_hold_addr", {26'd0, imem_addr}, 32'd5);
        chk("refill_head",      {24'd0, inst_pc},   32'h04);
        inst_ready = 1'b1;
        cyc();
        chk("drain_pc8",  {24'd0, inst_pc}, 32'h08);
        cyc();
        chk("drain_pcC",  {24'd0, inst_pc}, 32'h0C);
        cyc();
        chk("pushed_pc",   {24'd0, inst_pc}, 32'h10);
        chk("pushed_data", inst_data,        32'hA000_0004);

        // fetch_en low: no pushes, existing entries drain only when popped
        fetch_en   = 1'b0;
        inst_ready = 1'b0;
        cyc();
        cyc();
        chk("stop_cnt",  {28'd0, q_count},   32'd3);
        chk("stop_addr", {26'd0, imem_addr}, 32'd7);
        inst_ready = 1'b1;
        for (int i = 0; i < 4; i++) cyc();
        chk("stop_drain_cnt",  {28'd0, q_count},   32'd0);
        chk("stop_drain_addr", {26'd0, imem_addr}, 32'd7);

        // Redirect while three entries are queued
        fetch_en   = 1'b1;
        inst_ready = 1'b0;
        do_reset();
        for (int i = 0; i < 4; i++) cyc();
        chk("redir_pre_cnt", {28'd0, q_count}, 32'd3);
        inst_ready     = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 8'h20;
        cyc();
        redirect_valid = 1'b0;
        chk("redir_cnt",   {28'd0, q_count},    32'd0);
        chk("redir_valid", {31'd0, inst_valid}, 32'd0);
        chk("redir_addr",  {26'd0, imem_addr},  32'd8);
        cyc();
        chk("redir_pc",   {24'd0, inst_pc}, 32'h20);
        chk("redir_data", inst_data,        32'hA000_0008);
        cyc();
        chk("redir_pc2",  {24'd0, inst_pc}, 32'h24);

        // Misaligned redirect sets the sticky flag
        redirect_valid = 1'b1;
        redirect_pc    = 8'h21;
        cyc();
        redirect_valid = 1'b0;
        chk("mis_flag", {31'd0, misalign_err}, 32'd1);
        chk("mis_addr", {26'd0, imem_addr},    32'd8);
        cyc();
        chk("mis_pc",   {24'd0, inst_pc}, 32'h20);
        redirect_valid = 1'b1;
        redirect_pc    = 8'h40;
        cyc();
        redirect_valid = 1'b0;
        chk("mis_sticky", {31'd0, misalign_err}, 32'd1);
        cyc();

        // Fetch PC wraps past 8'hFC
        redirect_valid = 1'b1;
        redirect_pc    = 8'hF8;
        cyc();
        redirect_valid = 1'b0;
        chk("wrap_addr", {26'd0, imem_addr}, 32'h3E);
        cyc();
        chk("wrap_pcF8",   {24'd0, inst_pc}, 32'hF8);
        chk("wrap_dataF8", inst_data,        32'hA000_003E);
        cyc();
        chk("wrap_pcFC",   {24'd0, inst_pc}, 32'hFC);
        cyc();
        chk("wrap_pc00",   {24'd0, inst_pc}, 32'h00);
        chk("wrap_data00", inst_data,        32'hA000_0000);
        cyc();
        chk("wrap_pc04",   {24'd0, inst_pc}, 32'h04);

        // Asynchronous reset between edges with two entries queued
        inst_ready = 1'b0;
        do_reset();
        cyc();
        cyc();
        cyc();
        chk("areset_pre_cnt", {28'd0, q_count}, 32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("areset_valid",    {31'd0, inst_valid},   32'd0);
        chk("areset_cnt",      {28'd0, q_count},      32'd0);
        chk("areset_pc",       {24'd0, inst_pc},      32'd0);
        chk("areset_misalign", {31'd0, misalign_err}, 32'd0);
        cyc();
        rst_n      = 1'b1;
        inst_ready = 1'b1;
        cyc();
        cyc();
        chk("areset_first_pc", {24'd0, inst_pc}, {24'd0, RESET_PC});
        chk("areset_first_data", inst_data, 32'hA000_0000 + {26'd0, RESET_PC[7:2]});
        cyc();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
